// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans key levels one per cycle, assigns pressed keys to
// tone-generator slots (lowest free slot, else oldest slot when stealing is on).
// Ports:
//   CLOCK_50     system clock
//   reset        asynchronous active-high reset
//   scan_en      1: scanner advances; 0: scanner and voices hold
//   key_in       key levels (1 = pressed), already synchronous
//   voice_active per-slot sounding flag
//   voice_key    per-slot key index, slot v at bits v*KEY_W +: KEY_W
//   voice_start  one-cycle pulse when a slot is (re)assigned
//   drop_count   presses dropped when all slots busy (no stealing), saturating
module voice_allocator #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4,
    parameter int STEAL_EN   = 1
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        scan_en,
    input  logic [NUM_KEYS-1:0]         key_in,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       voice_start,
    output logic [7:0]                  drop_count
);

    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AGE_W = VW;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(NUM_VOICES - 1);
    localparam logic [KEY_W-1:0] PTR_LAST = KEY_W'(NUM_KEYS - 1);

    logic [KEY_W-1:0]                       ptr_q, ptr_d;
    logic [NUM_KEYS-1:0]                    prev_q, prev_d;
    logic [NUM_VOICES-1:0]                  act_q, act_d;
    logic [NUM_VOICES-1:0][KEY_W-1:0]       key_q, key_d;
    logic [NUM_VOICES-1:0]                  start_q, start_d;
    logic [7:0]                             drop_q, drop_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0]       age_q, age_d;

    logic             cur, prv, press, rel;
    logic             free_ok, own_ok;
    logic [VW-1:0]    free_v, old_v, own_v, sel_v;
    logic [AGE_W-1:0] old_age;

    // Slot searches: lowest free slot, oldest slot (ties to lowest index),
    // and the slot currently owning the scanned key.
    always_comb begin
        cur     = key_in[ptr_q];
        prv     = prev_q[ptr_q];
        press   = scan_en & cur & ~prv;
        rel     = scan_en & ~cur & prv;
        free_ok = 1'b0;
        free_v  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!act_q[v]) begin
                free_ok = 1'b1;
                free_v  = VW'(v);
            end
        end
        old_v   = '0;
        old_age = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_v   = VW'(v);
                old_age = age_q[v];
            end
        end
        own_ok = 1'b0;
        own_v  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (act_q[v] && key_q[v] == ptr_q) begin
                own_ok = 1'b1;
                own_v  = VW'(v);
            end
        end
        sel_v = free_ok ? free_v : old_v;
    end

    always_comb begin
        ptr_d   = ptr_q;
        prev_d  = prev_q;
        act_d   = act_q;
        key_d   = key_q;
        start_d = '0;
        drop_d  = drop_q;
        age_d   = age_q;
        if (scan_en) begin
            ptr_d         = (ptr_q == PTR_LAST) ? '0 : ptr_q + KEY_W'(1);
            prev_d[ptr_q] = cur;
        end
        if (press) begin
            if (free_ok || STEAL_EN != 0) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (VW'(v) == sel_v) begin
                        act_d[v]   = 1'b1;
                        key_d[v]   = ptr_q;
                        start_d[v] = 1'b1;
                        age_d[v]   = '0;
                    end else if (act_q[v] && age_q[v] != AGE_MAX) begin
                        age_d[v] = age_q[v] + AGE_W'(1);
                    end
                end
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
        // A key that lost its slot to stealing or was dropped has no owner.
        if (rel && own_ok) begin
            act_d[own_v] = 1'b0;
            age_d[own_v] = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            prev_q  <= '0;
            act_q   <= '0;
            key_q   <= '0;
            start_q <= '0;
            drop_q  <= '0;
            age_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            prev_q  <= prev_d;
            act_q   <= act_d;
            key_q   <= key_d;
            start_q <= start_d;
            drop_q  <= drop_d;
            age_q   <= age_d;
        end
    end

    assign voice_active = act_q;
    assign voice_key    = key_q;
    assign voice_start  = start_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a stealing and a dropping instance share stimulus
// and are checked every cycle against a slot/sequence-number reference model.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [11:0] key_in;

    logic [3:0]  va_s, vs_s, va_d, vs_d;
    logic [15:0] vk_s, vk_d;
    logic [7:0]  dc_s, dc_d;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    voice_allocator #(.NUM_KEYS(12), .NUM_VOICES(4), .KEY_W(4), .STEAL_EN(1)) u_steal (
        .CLOCK_50(clk), .reset(rst), .scan_en(scan_en), .key_in(key_in),
        .voice_active(va_s), .voice_key(vk_s), .voice_start(vs_s), .drop_count(dc_s)
    );

    voice_allocator #(.NUM_KEYS(12), .NUM_VOICES(4), .KEY_W(4), .STEAL_EN(0)) u_drop (
        .CLOCK_50(clk), .reset(rst), .scan_en(scan_en), .key_in(key_in),
        .voice_active(va_d), .voice_key(vk_d), .voice_start(vs_d), .drop_count(dc_d)
    );

    // Reference model, index 0 = stealing instance, 1 = dropping instance.
    // A slot's age is the number of assignments made since it was assigned,
    // capped at 3, derived from a per-instance assignment counter.
    bit m_act[2][4];
    int m_key[2][4];
    int m_seq[2][4];
    bit m_start[2][4];
    int m_drop[2];
    int m_cnt[2];
    int m_ptr;
    bit m_prev[12];

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 4; v++) begin
                m_act[s][v] = 0; m_key[s][v] = 0;
                m_seq[s][v] = 0; m_start[s][v] = 0;
            end
            m_drop[s] = 0; m_cnt[s] = 0;
        end
        m_ptr = 0;
        for (int k = 0; k < 12; k++) m_prev[k] = 0;
    endtask

    task automatic model_update();
        int k, sel, best, a;
        bit cur, pv;
        if (rst) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++)
            for (int v = 0; v < 4; v++) m_start[s][v] = 0;
        if (!scan_en) return;
        k   = m_ptr;
        cur = key_in[k];
        pv  = m_prev[k];
        for (int s = 0; s < 2; s++) begin
            if (cur && !pv) begin
                sel = -1;
                for (int v = 3; v >= 0; v--)
                    if (!m_act[s][v]) sel = v;
                if (sel < 0 && s == 0) begin
                    best = -1;
                    for (int v = 0; v < 4; v++) begin
                        a = m_cnt[s] - m_seq[s][v];
                        if (a > 3) a = 3;
                        if (a > best) begin best = a; sel = v; end
                    end
                end
                if (sel >= 0) begin
                    m_cnt[s]++;
                    m_seq[s][sel]   = m_cnt[s];
                    m_act[s][sel]   = 1;
                    m_key[s][sel]   = k;
                    m_start[s][sel] = 1;
                end else if (m_drop[s] < 255) begin
                    m_drop[s]++;
                end
            end else if (!cur && pv) begin
                for (int v = 0; v < 4; v++)
                    if (m_act[s][v] && m_key[s][v] == k) m_act[s][v] = 0;
            end
        end
        m_prev[k] = cur;
        m_ptr = (m_ptr + 1) % 12;
    endtask

    function automatic logic [3:0] e_act(int s);
        logic [3:0] r;
        for (int v = 0; v < 4; v++) r[v] = m_act[s][v];
        return r;
    endfunction

    function automatic logic [3:0] e_start(int s);
        logic [3:0] r;
        for (int v = 0; v < 4; v++) r[v] = m_start[s][v];
        return r;
    endfunction

    function automatic logic [15:0] e_key(int s);
        logic [15:0] r;
        for (int v = 0; v < 4; v++) r[v*4 +: 4] = 4'(m_key[s][v]);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("steal_active", 32'(va_s), 32'(e_act(0)));
        chk("steal_key",    32'(vk_s), 32'(e_key(0)));
        chk("steal_start",  32'(vs_s), 32'(e_start(0)));
        chk("steal_drop",   32'(dc_s), 32'(m_drop[0]));
        chk("drop_active",  32'(va_d), 32'(e_act(1)));
        chk("drop_key",     32'(vk_d), 32'(e_key(1)));
        chk("drop_start",   32'(vs_d), 32'(e_start(1)));
        chk("drop_count",   32'(dc_d), 32'(m_drop[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    initial begin
        logic [3:0] snap;
        bit seen;
        int cnt;
        rst = 1'b1;
        scan_en = 1'b1;
        key_in = '0;
        model_reset();
        #1;
        check_all();
        run(2);
        rst = 1'b0;

        // First press after reset: slot 0, bounded wait of one sweep plus one
        key_in[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 13 && !seen; i++) begin
            step();
            if (va_s[0]) seen = 1;
        end
        chk("key0_alloc_latency", 32'(seen), 32'd1);
        chk("key0_slot0_key", 32'(vk_s[3:0]), 32'd0);
        key_in[0] = 1'b0;
        run(24);

        // Fill all four slots in order
        key_in[2] = 1'b1; run(12);
        key_in[5] = 1'b1; run(12);
        key_in[7] = 1'b1; run(12);
        key_in[9] = 1'b1; run(12);
        chk("fill_keys", 32'(vk_s), 32'h9752);
        chk("fill_active", 32'(va_s), 32'hF);

        // Fifth press: steal oldest (slot 0) vs drop
        key_in[11] = 1'b1; run(12);
        chk("steal_slot0", 32'(vk_s), 32'h975B);
        chk("drop_unchanged", 32'(vk_d), 32'h9752);
        chk("drop_one", 32'(dc_d), 32'd1);

        // Release of a stolen key finds no owner
        key_in[2] = 1'b0; run(12);
        chk("stolen_release", 32'(va_s), 32'hF);
        key_in[5] = 1'b0; run(12);
        chk("release5", 32'(va_s), 32'hD);
        key_in[4] = 1'b1; run(12);
        chk("reuse_slot1", 32'(vk_s), 32'h974B);

        // Saturate the drop counter
        key_in[0] = 1'b1; run(12);
        for (int i = 0; i < 45; i++) begin
            key_in = key_in | 12'b0101_0110_1110;
            run(12);
            key_in = key_in & ~12'b0101_0110_1110;
            run(12);
        end
        chk("drop_saturated", 32'(dc_d), 32'd255);

        key_in = '0;
        run(12);

        // Reset mid-sweep with three keys held
        key_in = 12'b0000_0100_1010;
        run(5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("reset_async_active", 32'(va_s), 32'd0);
        run(2);
        rst = 1'b0;
        run(12);
        cnt = 0;
        for (int v = 0; v < 4; v++) cnt += int'(va_s[v]);
        chk("realloc_after_reset", 32'(cnt), 32'd3);

        // Scanner frozen: no events while keys toggle
        snap = va_s;
        scan_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            key_in[$urandom_range(0, 11)] ^= 1'b1;
            step();
        end
        chk("frozen_active", 32'(va_s), 32'(snap));
        scan_en = 1'b1;

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) key_in[$urandom_range(0, 11)] ^= 1'b1;
            scan_en = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
